branch_update_scheduler: RTL and testbench

- Sits between the execute-stage branch resolution and the combined (local/global/chooser) branch predictor.
- Buffers resolved-branch feedback in a small FIFO and drains it to the predictor's feedback port at one update per cycle under ready backpressure.
- Sequences a table-clear walk after reset and on flush requests.
- Gates fetch-side predictor lookups while clearing is in progress.

---
 rtl/branch_update_scheduler_pkg.sv | 27 ++
 rtl/branch_update_scheduler_fifo.sv | 60 ++++++
 rtl/branch_update_scheduler.sv | 170 +++++++++++++++++
 tb/tb_branch_update_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_update_scheduler_pkg.sv
// rtl/branch_update_scheduler_pkg.sv - shared types for the branch update scheduler
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package branch_update_scheduler_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    // One resolved-branch feedback record as it travels through the queue
    typedef struct packed {
        logic [`ADDR_WIDTH-1:0] pc;
        BranchOutcome           prediction;
        BranchOutcome           prediction1;
        BranchOutcome           prediction2;
        BranchOutcome           outcome;
    } BranchFbEntry;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } BranchSchedState;

endpackage

// File: rtl/branch_update_scheduler_fifo.sv
// rtl/branch_update_scheduler_fifo.sv - DEPTH-entry synchronous feedback FIFO (module branch_fb_fifo)
module branch_fb_fifo
    import branch_update_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  BranchFbEntry             data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output BranchFbEntry             head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    BranchFbEntry       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               do_push;
    logic               do_pop;

    // Full/empty come only from the registered count, so a pop never frees a slot for the same cycle
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Entry storage; contents are only meaningful under count, so it carries no reset
    always_ff @(posedge clk) begin
        if (do_push && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); flush drops everything queued
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/branch_update_scheduler.sv
// rtl/branch_update_scheduler.sv - feedback queue, table-clear walk and fetch gating; stats under BRANCH_UPDATE_SCHED_STATS_EN
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_update_scheduler
    import branch_update_scheduler_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int INDEX_BITS = 6,
    parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_fb_valid,
    input  logic [ADDR_WIDTH-1:0]   i_fb_pc,
    input  BranchOutcome            i_fb_prediction,
    input  BranchOutcome            i_fb_prediction1,
    input  BranchOutcome            i_fb_prediction2,
    input  BranchOutcome            i_fb_outcome,
    output logic                    o_fb_ready,
    input  logic                    i_flush_req,
    output logic                    o_upd_valid,
    output logic [ADDR_WIDTH-1:0]   o_upd_pc,
    output BranchOutcome            o_upd_prediction,
    output BranchOutcome            o_upd_prediction1,
    output BranchOutcome            o_upd_prediction2,
    output BranchOutcome            o_upd_outcome,
    input  logic                    i_upd_ready,
    output logic                    o_clr_valid,
    output logic [INDEX_BITS-1:0]   o_clr_index,
    output logic                    o_req_stall,
    output logic                    o_busy
`ifdef BRANCH_UPDATE_SCHED_STATS_EN
   ,output logic [15:0]             o_drop_count
   ,output logic [31:0]             o_upd_count
   ,output logic [$clog2(DEPTH):0]  o_max_occ
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    BranchSchedState        state_q;
    logic [INDEX_BITS-1:0]  clr_idx_q;
    logic                   clr_valid_q;
    logic                   stall_q;

    BranchFbEntry           fb_entry;
    BranchFbEntry           head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [PTR_W:0]         fifo_count;
    logic                   push;
    logic                   pop;

    assign fb_entry.pc          = i_fb_pc;
    assign fb_entry.prediction  = i_fb_prediction;
    assign fb_entry.prediction1 = i_fb_prediction1;
    assign fb_entry.prediction2 = i_fb_prediction2;
    assign fb_entry.outcome     = i_fb_outcome;

    assign o_fb_ready  = !fifo_full;
    assign push        = i_fb_valid && o_fb_ready;
    assign o_upd_valid = (state_q == RUN) && !fifo_empty;
    assign pop         = o_upd_valid && i_upd_ready;

    assign o_upd_pc          = head.pc;
    assign o_upd_prediction  = head.prediction;
    assign o_upd_prediction1 = head.prediction1;
    assign o_upd_prediction2 = head.prediction2;
    assign o_upd_outcome     = head.outcome;

    assign o_clr_valid = clr_valid_q;
    assign o_clr_index = clr_idx_q;
    assign o_req_stall = stall_q;
    assign o_busy      = (state_q == CLEAR) || !fifo_empty;

    branch_fb_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (i_flush_req),
        .data_i  (fb_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (head)
    );

    // Clear walk FSM: one table entry per cycle, then RUN; a flush restarts the walk from index 0
    always_ff @(posedge clk) begin
        if (rst || i_flush_req) begin
            state_q     <= CLEAR;
            clr_idx_q   <= '0;
            clr_valid_q <= 1'b1;
            stall_q     <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_idx_q == '1) begin
                        state_q     <= RUN;
                        clr_idx_q   <= '0;
                        clr_valid_q <= 1'b0;
                        stall_q     <= 1'b0;
                    end else begin
                        clr_idx_q   <= clr_idx_q + 1'b1;
                    end
                end
                RUN: begin
                    clr_valid_q <= 1'b0;
                    stall_q     <= 1'b0;
                end
                default: begin
                    state_q     <= CLEAR;
                    clr_idx_q   <= '0;
                    clr_valid_q <= 1'b1;
                    stall_q     <= 1'b1;
                end
            endcase
        end
    end

`ifdef BRANCH_UPDATE_SCHED_STATS_EN
    logic [15:0]    drop_cnt_q, drop_cnt_d;
    logic [31:0]    upd_cnt_q, upd_cnt_d;
    logic [PTR_W:0] max_occ_q, max_occ_d;
    logic [PTR_W:0] count_next;

    // Next-cycle occupancy so the peak tracks the count the FIFO is about to hold
    assign count_next = i_flush_req ? '0
                      : fifo_count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    // Drops saturate, updates wrap; a pop in a flush cycle is discarded and not counted
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        upd_cnt_d  = upd_cnt_q;
        max_occ_d  = max_occ_q;
        if (i_fb_valid && !o_fb_ready && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (pop && !i_flush_req) begin
            upd_cnt_d = upd_cnt_q + 32'd1;
        end
        if (count_next > max_occ_q) begin
            max_occ_d = count_next;
        end
    end

    // Statistics survive flush; only reset clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
            upd_cnt_q  <= '0;
            max_occ_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            upd_cnt_q  <= upd_cnt_d;
            max_occ_q  <= max_occ_d;
        end
    end

    assign o_drop_count = drop_cnt_q;
    assign o_upd_count  = upd_cnt_q;
    assign o_max_occ    = max_occ_q;
`endif

endmodule

// File: tb/tb_branch_update_scheduler.sv
// tb/tb_branch_update_scheduler.sv - randomized and directed bench for branch_update_scheduler
module tb_branch_update_scheduler;
    import branch_update_scheduler_pkg::*;

    localparam int DEPTH      = 4;
    localparam int INDEX_BITS = 6;
    localparam int NUM_IDX    = 1 << INDEX_BITS;

    logic                  clk;
    logic                  rst;
    logic                  fb_valid;
    logic [31:0]           fb_pc;
    BranchOutcome          fb_pred, fb_pred1, fb_pred2, fb_outcome;
    logic                  fb_ready;
    logic                  flush_req;
    logic                  upd_valid;
    logic [31:0]           upd_pc;
    BranchOutcome          upd_pred, upd_pred1, upd_pred2, upd_outcome;
    logic                  upd_ready;
    logic                  clr_valid;
    logic [INDEX_BITS-1:0] clr_index;
    logic                  req_stall;
    logic                  busy;
`ifdef BRANCH_UPDATE_SCHED_STATS_EN
    logic [15:0]           drop_count;
    logic [31:0]           upd_count;
    logic [2:0]            max_occ;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue contents, clear-walk position and statistics
    BranchFbEntry m_q[$];
    bit           m_clear;
    int           m_idx;
    int           m_drops;
    int           m_pops;
    int           m_max;

    branch_update_scheduler #(
        .DEPTH(DEPTH), .INDEX_BITS(INDEX_BITS), .ADDR_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst),
        .i_fb_valid(fb_valid), .i_fb_pc(fb_pc),
        .i_fb_prediction(fb_pred), .i_fb_prediction1(fb_pred1),
        .i_fb_prediction2(fb_pred2), .i_fb_outcome(fb_outcome),
        .o_fb_ready(fb_ready), .i_flush_req(flush_req),
        .o_upd_valid(upd_valid), .o_upd_pc(upd_pc),
        .o_upd_prediction(upd_pred), .o_upd_prediction1(upd_pred1),
        .o_upd_prediction2(upd_pred2), .o_upd_outcome(upd_outcome),
        .i_upd_ready(upd_ready), .o_clr_valid(clr_valid),
        .o_clr_index(clr_index), .o_req_stall(req_stall), .o_busy(busy)
`ifdef BRANCH_UPDATE_SCHED_STATS_EN
       ,.o_drop_count(drop_count), .o_upd_count(upd_count), .o_max_occ(max_occ)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic BranchFbEntry mk(input logic [31:0] pc);
        BranchFbEntry e;
        e.pc          = pc;
        e.prediction  = BranchOutcome'($urandom_range(0, 1));
        e.prediction1 = BranchOutcome'($urandom_range(0, 1));
        e.prediction2 = BranchOutcome'($urandom_range(0, 1));
        e.outcome     = BranchOutcome'($urandom_range(0, 1));
        return e;
    endfunction

    // Apply one cycle of inputs, advance the model by the same cycle, return at the next negedge
    task automatic drive(input logic v, input BranchFbEntry e, input logic rdy, input logic fl);
        int sz;
        bit popping, pushing;
        BranchFbEntry dummy;
        fb_valid = v; fb_pc = e.pc; fb_pred = e.prediction; fb_pred1 = e.prediction1;
        fb_pred2 = e.prediction2; fb_outcome = e.outcome; upd_ready = rdy; flush_req = fl;
        sz      = m_q.size();
        popping = !m_clear && (sz > 0) && rdy;
        pushing = v && (sz < DEPTH);
        if (v && !pushing && m_drops < 65535) m_drops++;
        if (fl) begin
            m_q.delete();
            m_clear = 1'b1;
            m_idx   = 0;
        end else begin
            if (popping) begin
                dummy = m_q.pop_front();
                m_pops++;
            end
            if (pushing) m_q.push_back(e);
            if (m_clear) begin
                if (m_idx == NUM_IDX - 1) begin
                    m_clear = 1'b0;
                    m_idx   = 0;
                end else begin
                    m_idx++;
                end
            end
        end
        if (m_q.size() > m_max) m_max = m_q.size();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; fb_valid = 1'b0; flush_req = 1'b0; upd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_q.delete(); m_clear = 1'b1; m_idx = 0; m_drops = 0; m_pops = 0; m_max = 0;
    endtask

    task automatic test_reset();
        do_reset();
`ifdef BRANCH_UPDATE_SCHED_STATS_EN
        n_checks++;
        if (drop_count !== 16'd0 || upd_count !== 32'd0 || max_occ !== 3'd0) begin
            n_fail++; $display("FAIL reset_stats got %0d/%0d/%0d exp 0/0/0", drop_count, upd_count, max_occ);
        end
`endif
        for (int i = 0; i < NUM_IDX; i++) begin
            n_checks++;
            if (clr_valid !== 1'b1 || clr_index !== INDEX_BITS'(i) || req_stall !== 1'b1 || busy !== 1'b1) begin
                n_fail++; $display("FAIL reset_walk i=%0d got clr_valid=%0b idx=%0d stall=%0b busy=%0b", i, clr_valid, clr_index, req_stall, busy);
            end
            n_checks++;
            if (fb_ready !== 1'b1 || upd_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_fifo i=%0d got ready=%0b upd_valid=%0b exp 1/0", i, fb_ready, upd_valid);
            end
            drive_idle();
        end
        n_checks++;
        if (clr_valid !== 1'b0 || req_stall !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_run got clr_valid=%0b stall=%0b busy=%0b exp 0/0/0", clr_valid, req_stall, busy);
        end
    endtask

    task automatic test_order();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, mk(pcs[k]), 1'b1, 1'b0);
            n_checks++;
            if (upd_valid !== 1'b1 || upd_pc !== pcs[k]) begin
                n_fail++; $display("FAIL order k=%0d got valid=%0b pc=%h exp 1/%h", k, upd_valid, upd_pc, pcs[k]);
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (busy !== 1'b0 || upd_valid !== 1'b0) begin
            n_fail++; $display("FAIL order_idle got busy=%0b valid=%0b exp 0/0", busy, upd_valid);
        end
    endtask

    task automatic test_full_drop();
        BranchFbEntry e [5];
        BranchFbEntry got;
        for (int k = 0; k < 5; k++) e[k] = mk(32'h2000 + 32'(k * 4));
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, e[k], 1'b0, 1'b0);
            n_checks++;
            if (fb_ready !== (k < 3)) begin
                n_fail++; $display("FAIL full_ready k=%0d got %0b exp %0b", k, fb_ready, (k < 3));
            end
        end
`ifdef BRANCH_UPDATE_SCHED_STATS_EN
        n_checks++;
        if (drop_count !== 16'd1 || max_occ !== 3'd4) begin
            n_fail++; $display("FAIL full_stats got drops=%0d max=%0d exp 1/4", drop_count, max_occ);
        end
`endif
        for (int k = 0; k < 4; k++) begin
            got = '{pc: upd_pc, prediction: upd_pred, prediction1: upd_pred1, prediction2: upd_pred2, outcome: upd_outcome};
            n_checks++;
            if (upd_valid !== 1'b1 || got !== e[k]) begin
                n_fail++; $display("FAIL full_drain k=%0d got valid=%0b entry=%h exp %h", k, upd_valid, got, e[k]);
            end
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        n_checks++;
        if (upd_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL full_empty got valid=%0b busy=%0b exp 0/0", upd_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        for (int k = 0; k < DEPTH; k++) drive(1'b1, mk(32'h3000 + 32'(k * 4)), 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, mk(32'h4000 + 32'(k * 4)), 1'b1, 1'b0);
            n_checks++;
            if (fb_ready !== (m_q.size() < DEPTH) || upd_valid !== 1'b1 || upd_pc !== m_q[0].pc) begin
                n_fail++; $display("FAIL b2b k=%0d got ready=%0b valid=%0b pc=%h exp %0b/1/%h", k, fb_ready, upd_valid, upd_pc, (m_q.size() < DEPTH), m_q[0].pc);
            end
        end
        guard = 0;
        while (m_q.size() > 0 && guard < 10) begin
            n_checks++;
            if (upd_pc !== m_q[0].pc) begin
                n_fail++; $display("FAIL b2b_drain got pc=%h exp %h", upd_pc, m_q[0].pc);
            end
            drive(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_done got busy=%0b exp 0", busy);
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) drive(1'b1, mk(32'h5000 + 32'(k * 4)), 1'b0, 1'b0);
        drive(1'b1, mk(32'h6000), 1'b1, 1'b1);
        n_checks++;
        if (upd_valid !== 1'b0 || fb_ready !== 1'b1 || clr_valid !== 1'b1 || clr_index !== '0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL flush got valid=%0b ready=%0b clr=%0b idx=%0d busy=%0b exp 0/1/1/0/1", upd_valid, fb_ready, clr_valid, clr_index, busy);
        end
        for (int i = 0; i < NUM_IDX; i++) begin
            n_checks++;
            if (clr_valid !== 1'b1 || clr_index !== INDEX_BITS'(i) || req_stall !== 1'b1) begin
                n_fail++; $display("FAIL flush_walk i=%0d got clr=%0b idx=%0d stall=%0b", i, clr_valid, clr_index, req_stall);
            end
            drive_idle();
        end
        n_checks++;
        if (req_stall !== 1'b0 || upd_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_end got stall=%0b valid=%0b busy=%0b exp 0/0/0", req_stall, upd_valid, busy);
        end
    endtask

    task automatic test_rst_mid_clear();
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b1, mk($urandom), 1'b1, 1'b0);
        n_checks++;
        if (clr_index !== 6'd20 || fb_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_clear got idx=%0d ready=%0b exp 20/0", clr_index, fb_ready);
        end
        do_reset();
        n_checks++;
        if (clr_index !== '0 || clr_valid !== 1'b1 || fb_ready !== 1'b1 || upd_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_rst got idx=%0d clr=%0b ready=%0b valid=%0b busy=%0b", clr_index, clr_valid, fb_ready, upd_valid, busy);
        end
`ifdef BRANCH_UPDATE_SCHED_STATS_EN
        n_checks++;
        if (drop_count !== 16'd0 || upd_count !== 32'd0 || max_occ !== 3'd0) begin
            n_fail++; $display("FAIL mid_rst_stats got %0d/%0d/%0d exp 0/0/0", drop_count, upd_count, max_occ);
        end
`endif
        for (int i = 0; i < NUM_IDX; i++) drive_idle();
        n_checks++;
        if (busy !== 1'b0 || upd_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_end got busy=%0b valid=%0b exp 0/0", busy, upd_valid);
        end
    endtask

    task automatic test_random();
        BranchFbEntry got;
        for (int c = 0; c < 1500; c++) begin
            drive(($urandom_range(0, 9) < 6), mk($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
            got = '{pc: upd_pc, prediction: upd_pred, prediction1: upd_pred1, prediction2: upd_pred2, outcome: upd_outcome};
            n_checks++;
            if (fb_ready !== (m_q.size() < DEPTH) || upd_valid !== (!m_clear && m_q.size() > 0) || busy !== (m_clear || m_q.size() > 0)) begin
                n_fail++; $display("FAIL rand_ctl c=%0d got ready=%0b valid=%0b busy=%0b size=%0d clear=%0b", c, fb_ready, upd_valid, busy, m_q.size(), m_clear);
            end
            n_checks++;
            if (clr_valid !== m_clear || req_stall !== m_clear || (m_clear && clr_index !== INDEX_BITS'(m_idx))) begin
                n_fail++; $display("FAIL rand_clr c=%0d got clr=%0b stall=%0b idx=%0d exp %0b/%0d", c, clr_valid, req_stall, clr_index, m_clear, m_idx);
            end
            if (m_q.size() > 0 && !m_clear) begin
                n_checks++;
                if (got !== m_q[0]) begin
                    n_fail++; $display("FAIL rand_head c=%0d got %h exp %h", c, got, m_q[0]);
                end
            end
`ifdef BRANCH_UPDATE_SCHED_STATS_EN
            n_checks++;
            if (drop_count !== 16'(m_drops) || upd_count !== 32'(m_pops) || max_occ !== 3'(m_max)) begin
                n_fail++; $display("FAIL rand_stats c=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", c, drop_count, upd_count, max_occ, m_drops, m_pops, m_max);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; fb_valid = 1'b0; fb_pc = '0; fb_pred = NOT_TAKEN; fb_pred1 = NOT_TAKEN;
        fb_pred2 = NOT_TAKEN; fb_outcome = NOT_TAKEN; flush_req = 1'b0; upd_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_order();
        test_full_drop();
        test_back_to_back();
        test_flush();
        test_rst_mid_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
